armleo_axi_write_mux: RTL
=========================

Name: armleo_axi_write_mux

Overview:
- N-host to 1-device AXI4 write multiplexer; the write-channel counterpart of the read mux.
- Sits between several AXI write initiators (cores, DMA) and a single write port (interconnect/memory controller).
- Round-robin arbitration on AW; the granted host owns AW, W and B until its B handshake completes.
- One outstanding write burst at a time.

Parameters:
- HOST_NUMBER, 5, number of upstream hosts (>=2); HOST_NUMBER_CLOG2 = $clog2(HOST_NUMBER) is local.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; DATA_STROBES = DATA_WIDTH/8 is local.
- ID_WIDTH, 4, transaction ID width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- upstream_axi_awvalid/awready  in/out  HOST_NUMBER  per-host AW handshake.
- upstream_axi_awaddr  in  HOST_NUMBER*ADDR_WIDTH.
- upstream_axi_awlen  in  HOST_NUMBER*8.
- upstream_axi_awsize, upstream_axi_awprot  in  HOST_NUMBER*3.
- upstream_axi_awburst  in  HOST_NUMBER*2.
- upstream_axi_awid  in  HOST_NUMBER*ID_WIDTH.
- upstream_axi_awlock  in  HOST_NUMBER.
- upstream_axi_wvalid/wready  in/out  HOST_NUMBER.
- upstream_axi_wdata  in  HOST_NUMBER*DATA_WIDTH.
- upstream_axi_wstrb  in  HOST_NUMBER*DATA_STROBES.
- upstream_axi_wlast  in  HOST_NUMBER.
- upstream_axi_bvalid/bready  out/in  HOST_NUMBER.
- upstream_axi_bresp  out  HOST_NUMBER*2.
- upstream_axi_bid  out  HOST_NUMBER*ID_WIDTH.
- downstream_axi_aw*, w*, b*: single AXI4 write host port with the same field widths; directions mirrored.

Behaviour:
- Slice i of every packed vector is bits [i*W +: W].
- State: IDLE, DATA, RESP. Registers: state, lock_idx, rr_ptr, aw_done, w_done.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, aw_done=w_done=0, rr_ptr=0.
  - All upstream awready/wready/bvalid=0; downstream awvalid/wvalid/bready=0.
  - No partial burst is resumed after reset.
- IDLE:
  - No outputs asserted.
  - If any awvalid: grant the first asserted host searching upward from rr_ptr, with wrap.
  - lock_idx<=grant, rr_ptr<=grant+1 (wraps to 0 after HOST_NUMBER-1), go to DATA.
  - Grant is registered: minimum 1 cycle from awvalid to downstream awvalid.
- DATA:
  - AW pass-through while !aw_done: downstream_awvalid = awvalid[lock_idx]; awready[lock_idx] = downstream_awready. AW payload is muxed from lock_idx.
  - On AW handshake: aw_done<=1.
  - W pass-through while !w_done, independent of AW; W before or simultaneous with AW is allowed. downstream_wvalid = wvalid[lock_idx]; wready[lock_idx] = downstream_wready.
  - On W handshake with wlast: w_done<=1.
  - Go to RESP when both are done, counting same-cycle handshakes; this can happen in one cycle.
- RESP:
  - bvalid[lock_idx] = downstream_bvalid; downstream_bready = bready[lock_idx].
  - bresp and bid are broadcast to all hosts; only lock_idx sees bvalid.
  - On B handshake: IDLE, clear done flags. The next grant is possible in the following cycle.
  - A downstream bvalid arriving before RESP is not accepted (bready=0) until RESP.
- Non-granted hosts always see awready=wready=bvalid=0; their requests wait indefinitely with no loss.
- Beats are not counted; burst end is determined by wlast only.
- Combinational paths: ready upstream←downstream and valid downstream←upstream. There are no registers in the data path.
- Out of scope: ID remapping, outstanding-transaction tracking, exclusive-access monitoring. awlock is passed through only.

Test Plan:
- Single host 2 writes awaddr=0x100, awlen=3, 4 W beats, downstream bresp=OKAY -> downstream sees the same addr/len/data/strb in order; host 2 gets bvalid with bid echoed; other hosts bvalid=0; state returns to IDLE.
- Hosts 0, 1 and 4 all assert awvalid from reset -> grant order 0, 1, 4, 0…; no host granted twice while another is waiting.
- Host 3 drives W (awlen=0, wlast=1) two cycles before AW -> W passes first, AW passes later; one B to host 3; downstream bvalid held off until both handshakes are done.
- Downstream awready=wready=1 in the same cycle as a single-beat write -> DATA→RESP in one cycle; downstream bvalid next cycle goes to the host with bready=1.
- Downstream wready toggled 1/0 during awlen=7 -> exactly 8 beats transferred, no duplication or drop; host 1 held off throughout and granted only after B.
- rst pulse mid-burst (after beat 2 of 4) -> all valids/readies drop asynchronously; after release, rr_ptr=0 and a new grant follows from IDLE.

Source files
------------

// File: rtl/armleo_axi_write_mux.sv
// N-to-1 AXI4 write multiplexer: round-robin on AW, and the granted host owns AW, W and B
// until its B handshake completes. Only one write burst is outstanding at a time.
module armleo_axi_write_mux #(
    parameter int HOST_NUMBER = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    localparam int HOST_NUMBER_CLOG2 = $clog2(HOST_NUMBER),
    localparam int DATA_STROBES = DATA_WIDTH / 8
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [HOST_NUMBER-1:0]             upstream_axi_awvalid,
    output logic [HOST_NUMBER-1:0]             upstream_axi_awready,
    input  logic [HOST_NUMBER*ADDR_WIDTH-1:0]  upstream_axi_awaddr,
    input  logic [HOST_NUMBER*8-1:0]           upstream_axi_awlen,
    input  logic [HOST_NUMBER*3-1:0]           upstream_axi_awsize,
    input  logic [HOST_NUMBER*2-1:0]           upstream_axi_awburst,
    input  logic [HOST_NUMBER*ID_WIDTH-1:0]    upstream_axi_awid,
    input  logic [HOST_NUMBER-1:0]             upstream_axi_awlock,
    input  logic [HOST_NUMBER*3-1:0]           upstream_axi_awprot,

    input  logic [HOST_NUMBER-1:0]             upstream_axi_wvalid,
    output logic [HOST_NUMBER-1:0]             upstream_axi_wready,
    input  logic [HOST_NUMBER*DATA_WIDTH-1:0]  upstream_axi_wdata,
    input  logic [HOST_NUMBER*DATA_STROBES-1:0] upstream_axi_wstrb,
    input  logic [HOST_NUMBER-1:0]             upstream_axi_wlast,

    output logic [HOST_NUMBER-1:0]             upstream_axi_bvalid,
    input  logic [HOST_NUMBER-1:0]             upstream_axi_bready,
    output logic [HOST_NUMBER*2-1:0]           upstream_axi_bresp,
    output logic [HOST_NUMBER*ID_WIDTH-1:0]    upstream_axi_bid,

    output logic                               downstream_axi_awvalid,
    input  logic                               downstream_axi_awready,
    output logic [ADDR_WIDTH-1:0]              downstream_axi_awaddr,
    output logic [7:0]                         downstream_axi_awlen,
    output logic [2:0]                         downstream_axi_awsize,
    output logic [1:0]                         downstream_axi_awburst,
    output logic [ID_WIDTH-1:0]                downstream_axi_awid,
    output logic                               downstream_axi_awlock,
    output logic [2:0]                         downstream_axi_awprot,

    output logic                               downstream_axi_wvalid,
    input  logic                               downstream_axi_wready,
    output logic [DATA_WIDTH-1:0]              downstream_axi_wdata,
    output logic [DATA_STROBES-1:0]            downstream_axi_wstrb,
    output logic                               downstream_axi_wlast,

    input  logic                               downstream_axi_bvalid,
    output logic                               downstream_axi_bready,
    input  logic [1:0]                         downstream_axi_bresp,
    input  logic [ID_WIDTH-1:0]                downstream_axi_bid,

    output logic [1:0]                         debug_state_o
);
    // Every channel uses AXI valid/ready: a transfer happens on the rising edge where both
    // are high; valid never waits on ready, and the mux only forwards, never buffers.
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_DATA = 2'd1;
    localparam logic [1:0] STATE_RESP = 2'd2;
    localparam int CW = HOST_NUMBER_CLOG2 + 1;
    localparam logic [HOST_NUMBER_CLOG2-1:0] IDX_ONE = HOST_NUMBER_CLOG2'(1);

    logic [1:0]                   state_q, state_d;
    logic [HOST_NUMBER_CLOG2-1:0] lock_idx_q, lock_idx_d;
    logic [HOST_NUMBER_CLOG2-1:0] rr_ptr_q, rr_ptr_d;
    logic                         aw_done_q, aw_done_d;
    logic                         w_done_q, w_done_d;

    logic                         grant_valid;
    logic [HOST_NUMBER_CLOG2-1:0] grant_idx;
    logic [CW-1:0]                cand;
    logic sel_awvalid, sel_wvalid, sel_bready;
    logic aw_open, w_open, b_open, aw_hs, w_last_hs, b_hs;

    assign debug_state_o = state_q;
    assign aw_open = (state_q == STATE_DATA) && !aw_done_q;
    assign w_open  = (state_q == STATE_DATA) && !w_done_q;
    assign b_open  = (state_q == STATE_RESP);

    // Round-robin search starting at rr_ptr, wrapping at HOST_NUMBER.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        cand = '0;
        for (int k = 0; k < HOST_NUMBER; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(HOST_NUMBER)) cand = cand - CW'(HOST_NUMBER);
            if (!grant_valid && upstream_axi_awvalid[cand]) begin
                grant_valid = 1'b1;
                grant_idx = cand[HOST_NUMBER_CLOG2-1:0];
            end
        end
    end

    always_comb begin
        sel_awvalid = 1'b0;
        sel_wvalid = 1'b0;
        sel_bready = 1'b0;
        downstream_axi_awaddr = '0;
        downstream_axi_awlen = '0;
        downstream_axi_awsize = '0;
        downstream_axi_awburst = '0;
        downstream_axi_awid = '0;
        downstream_axi_awlock = 1'b0;
        downstream_axi_awprot = '0;
        downstream_axi_wdata = '0;
        downstream_axi_wstrb = '0;
        downstream_axi_wlast = 1'b0;
        upstream_axi_awready = '0;
        upstream_axi_wready = '0;
        upstream_axi_bvalid = '0;
        for (int i = 0; i < HOST_NUMBER; i++) begin
            if (int'(lock_idx_q) == i) begin
                sel_awvalid = upstream_axi_awvalid[i];
                sel_wvalid = upstream_axi_wvalid[i];
                sel_bready = upstream_axi_bready[i];
                downstream_axi_awaddr = upstream_axi_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                downstream_axi_awlen = upstream_axi_awlen[i*8 +: 8];
                downstream_axi_awsize = upstream_axi_awsize[i*3 +: 3];
                downstream_axi_awburst = upstream_axi_awburst[i*2 +: 2];
                downstream_axi_awid = upstream_axi_awid[i*ID_WIDTH +: ID_WIDTH];
                downstream_axi_awlock = upstream_axi_awlock[i];
                downstream_axi_awprot = upstream_axi_awprot[i*3 +: 3];
                downstream_axi_wdata = upstream_axi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                downstream_axi_wstrb = upstream_axi_wstrb[i*DATA_STROBES +: DATA_STROBES];
                downstream_axi_wlast = upstream_axi_wlast[i];
                upstream_axi_awready[i] = aw_open && downstream_axi_awready;
                upstream_axi_wready[i] = w_open && downstream_axi_wready;
                upstream_axi_bvalid[i] = b_open && downstream_axi_bvalid;
            end
        end
    end

    assign downstream_axi_awvalid = aw_open && sel_awvalid;
    assign downstream_axi_wvalid  = w_open && sel_wvalid;
    assign downstream_axi_bready  = b_open && sel_bready;
    assign upstream_axi_bresp = {HOST_NUMBER{downstream_axi_bresp}};
    assign upstream_axi_bid   = {HOST_NUMBER{downstream_axi_bid}};

    assign aw_hs     = downstream_axi_awvalid && downstream_axi_awready;
    assign w_last_hs = downstream_axi_wvalid && downstream_axi_wready && downstream_axi_wlast;
    assign b_hs      = downstream_axi_bvalid && downstream_axi_bready;

    always_comb begin
        state_d = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d = w_done_q;
        case (state_q)
            STATE_IDLE: begin
                if (grant_valid) begin
                    lock_idx_d = grant_idx;
                    rr_ptr_d = ({1'b0, grant_idx} == CW'(HOST_NUMBER - 1)) ? '0 : grant_idx + IDX_ONE;
                    state_d = STATE_DATA;
                end
            end
            STATE_DATA: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_last_hs) w_done_d = 1'b1;
                // Same-cycle handshakes count, so DATA can last a single cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) state_d = STATE_RESP;
            end
            STATE_RESP: begin
                if (b_hs) begin
                    aw_done_d = 1'b0;
                    w_done_d = 1'b0;
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
        end
    end
endmodule
